count_sequence_monitor: RTL and testbench
=========================================

Name: count_sequence_monitor

Overview:
- Downstream checker for the free-running D-flip-flop binary up-counter.
- Samples the counter value on a strobe and verifies each sample equals the previous sample +1 modulo 2^WIDTH.
- Reports lock, wrap events, per-sample errors, a saturating error total, and a sticky fault after repeated consecutive errors.
- Status outputs feed the board-level LEDs and test logic.

Parameters:
- WIDTH, 3, bit width of the monitored counter value.
- LOCK_COUNT, 2, consecutive good increments needed to declare lock (>=1).
- FAULT_LIMIT, 3, consecutive mismatches in TRACK that force FAULT (>=1).
- ERR_CNT_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- cnt_in  input  WIDTH  counter value under test.
- cnt_valid  input  1  sample strobe; cnt_in is examined only when 1.
- clear  input  1  synchronous clear of errors and fault; returns the block to IDLE.
- locked  output  1  1 while in TRACK.
- wrap_pulse  output  1  one-cycle pulse on a correct max->0 transition in TRACK.
- err_pulse  output  1  one-cycle pulse on a mismatch in TRACK.
- err_count  output  ERR_CNT_W  total mismatches in TRACK; saturates at all-ones.
- fault  output  1  1 while in FAULT.
- expected  output  WIDTH  next value expected: last sample +1, mod 2^WIDTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0; prev, good_cnt and miss_cnt are 0.
- Registers update on the rising clk edge that samples cnt_valid=1; outputs are registered, so they are visible one cycle after the strobe.
- Priority is reset, then clear, then cnt_valid. When clear=1 in any state:
  - state=IDLE.
  - err_count=0; pulses=0; good_cnt=0 and miss_cnt=0.
  - Any simultaneous sample is discarded.
- cnt_valid=0: state and all counters hold; pulses are 0.
- IDLE: on valid, prev=cnt_in, good_cnt=0, go to ACQUIRE.
- ACQUIRE: on valid:
  - If cnt_in==prev+1 (mod 2^WIDTH), good_cnt++.
  - If the new good_cnt==LOCK_COUNT, go to TRACK with locked=1.
  - On mismatch, good_cnt=0; no err_pulse and no err_count change.
  - prev=cnt_in always.
- TRACK: on valid:
  - Match: miss_cnt=0. wrap_pulse=1 if prev==2^WIDTH-1 and cnt_in==0.
  - Mismatch, including a held value: err_pulse=1, err_count+1 saturating, miss_cnt++, resync prev=cnt_in.
  - If the new miss_cnt==FAULT_LIMIT, go to FAULT: locked=0, fault=1.
- FAULT: all samples ignored; expected, err_count and fault hold. Only clear or reset leaves FAULT.
- expected:
  - Updates to cnt_in+1 on every accepted sample in IDLE, ACQUIRE and TRACK.
  - Is 0 after reset or clear.
- Arithmetic: the increment wraps naturally at WIDTH bits; no sign handling. err_count never rolls over.
- wrap_pulse and err_pulse are mutually exclusive and never assert outside TRACK.
- Reset mid-operation aborts immediately with no residual pulse.

Test Plan (WIDTH=3, LOCK_COUNT=2, FAULT_LIMIT=3, ERR_CNT_W=4):
- Lock and wrap:
  - Stimulus: reset=0 for 2 cycles, then 1; cnt_valid=1 every cycle with cnt_in=0,1,2,...,7,0,1.
  - Response: locked=1 after the sample 2. wrap_pulse=1 for exactly the cycle after sample 0 follows 7. err_count=0 throughout. expected=2 after the final sample 1.
- Single glitch:
  - Stimulus: while locked, feed 3,5,6.
  - Response: err_pulse one cycle after 5, err_count=1, expected=6. locked stays 1; the sample 6 is a match and miss_cnt returns to 0.
- Fault entry and clear:
  - Stimulus: while locked, feed 4,0,0,0, then 5,6; then clear=1 for one cycle.
  - Response: err_count=3 and fault=1 / locked=0 after the third 0. Samples 5,6 change nothing (err_count stays 3). After clear, fault=0, err_count=0, state IDLE.
- Saturation:
  - Stimulus: while locked, 20 isolated mismatches, each followed by a correct sample.
  - Response: err_count reaches 15 and holds at 15. fault stays 0.
- Async reset mid-TRACK:
  - Stimulus: drive reset=0 between clock edges while locked with err_count=2.
  - Response: locked, err_count and expected go to 0 before the next edge. After release, the first good sample re-enters ACQUIRE, not TRACK.
- Clear/valid collision:
  - Stimulus: in TRACK, assert clear=1 with cnt_valid=1 and a mismatching cnt_in.
  - Response: err_pulse=0, err_count=0, state IDLE, expected=0.

Source files
------------

// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor
// Downstream checker for a free-running binary up-counter. Each strobed
// sample must equal the previous sample + 1 (mod 2^WIDTH). The monitor
// acquires lock, tracks wrap events and mismatches, and latches a fault
// after FAULT_LIMIT consecutive mismatches while tracking.
module count_sequence_monitor #(
  parameter int WIDTH       = 3,
  parameter int LOCK_COUNT  = 2,
  parameter int FAULT_LIMIT = 3,
  parameter int ERR_CNT_W   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,      // asynchronous, active-low
  input  logic [WIDTH-1:0]     i_cnt_in,
  input  logic                 i_cnt_valid,
  input  logic                 i_clear,
  output logic                 o_locked,
  output logic                 o_wrap_pulse,
  output logic                 o_err_pulse,
  output logic [ERR_CNT_W-1:0] o_err_count,
  output logic                 o_fault,
  output logic [WIDTH-1:0]     o_expected
);

  localparam int GOOD_W = (LOCK_COUNT  < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = (FAULT_LIMIT < 1) ? 1 : $clog2(FAULT_LIMIT + 1);

  localparam logic [WIDTH-1:0]     CNT_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0]     CNT_MAX   = '1;
  localparam logic [GOOD_W-1:0]    GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0]    GOOD_LOCK = GOOD_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]    MISS_ONE  = MISS_W'(1);
  localparam logic [MISS_W-1:0]    MISS_LIM  = MISS_W'(FAULT_LIMIT);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE   = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  // Registered state
  state_t                 r_state;
  logic [WIDTH-1:0]       r_prev;
  logic [GOOD_W-1:0]      r_good_cnt;
  logic [MISS_W-1:0]      r_miss_cnt;
  logic [ERR_CNT_W-1:0]   r_err_count;
  logic [WIDTH-1:0]       r_expected;
  logic                   r_wrap_pulse;
  logic                   r_err_pulse;

  // Next-state values
  state_t                 w_state;
  logic [WIDTH-1:0]       w_prev;
  logic [GOOD_W-1:0]      w_good_cnt;
  logic [MISS_W-1:0]      w_miss_cnt;
  logic [ERR_CNT_W-1:0]   w_err_count;
  logic [WIDTH-1:0]       w_expected;
  logic                   w_wrap_pulse;
  logic                   w_err_pulse;

  // Helpers shared by the next-state logic
  logic [WIDTH-1:0]       w_prev_inc;
  logic [WIDTH-1:0]       w_cnt_inc;
  logic                   w_match;
  logic [GOOD_W-1:0]      w_good_inc;
  logic [MISS_W-1:0]      w_miss_inc;
  logic [ERR_CNT_W-1:0]   w_err_sat;

  assign w_prev_inc = r_prev + CNT_ONE;
  assign w_cnt_inc  = i_cnt_in + CNT_ONE;
  assign w_match    = (i_cnt_in == w_prev_inc);
  assign w_good_inc = r_good_cnt + GOOD_ONE;
  assign w_miss_inc = r_miss_cnt + MISS_ONE;
  assign w_err_sat  = (r_err_count == ERR_MAX) ? ERR_MAX : (r_err_count + ERR_ONE);

  // Next-state and next-output decode: clear beats a strobe, FAULT ignores samples
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    w_state      = r_state;
    w_prev       = r_prev;
    w_good_cnt   = r_good_cnt;
    w_miss_cnt   = r_miss_cnt;
    w_err_count  = r_err_count;
    w_expected   = r_expected;
    w_wrap_pulse = 1'b0;
    w_err_pulse  = 1'b0;

    if (i_clear) begin
      w_state     = S_IDLE;
      w_prev      = '0;
      w_good_cnt  = '0;
      w_miss_cnt  = '0;
      w_err_count = '0;
      w_expected  = '0;
    end else if (i_cnt_valid) begin
      case (r_state)
        S_IDLE: begin
          w_prev     = i_cnt_in;
          w_expected = w_cnt_inc;
          w_good_cnt = '0;
          w_state    = S_ACQUIRE;
        end

        S_ACQUIRE: begin
          w_prev     = i_cnt_in;
          w_expected = w_cnt_inc;
          if (w_match) begin
            w_good_cnt = w_good_inc;
            if (w_good_inc == GOOD_LOCK) begin
              w_state    = S_TRACK;
              w_miss_cnt = '0;
            end
          end else begin
            w_good_cnt = '0;
          end
        end

        S_TRACK: begin
          // Resync on every sample so a single glitch costs one error only
          w_prev     = i_cnt_in;
          w_expected = w_cnt_inc;
          if (w_match) begin
            w_miss_cnt   = '0;
            w_wrap_pulse = (r_prev == CNT_MAX) && (i_cnt_in == '0);
          end else begin
            w_err_pulse = 1'b1;
            w_err_count = w_err_sat;
            w_miss_cnt  = w_miss_inc;
            if (w_miss_inc == MISS_LIM) begin
              w_state = S_FAULT;
            end
          end
        end

        S_FAULT: begin
          // Sticky: only clear or reset leaves this state
        end

        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_prev       <= '0;
      r_good_cnt   <= '0;
      r_miss_cnt   <= '0;
      r_err_count  <= '0;
      r_expected   <= '0;
      r_wrap_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      r_state      <= w_state;
      r_prev       <= w_prev;
      r_good_cnt   <= w_good_cnt;
      r_miss_cnt   <= w_miss_cnt;
      r_err_count  <= w_err_count;
      r_expected   <= w_expected;
      r_wrap_pulse <= w_wrap_pulse;
      r_err_pulse  <= w_err_pulse;
    end
  end

  assign o_locked     = (r_state == S_TRACK);
  assign o_fault      = (r_state == S_FAULT);
  assign o_wrap_pulse = r_wrap_pulse;
  assign o_err_pulse  = r_err_pulse;
  assign o_err_count  = r_err_count;
  assign o_expected   = r_expected;

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Directed testbench for count_sequence_monitor (WIDTH=3, LOCK_COUNT=2,
// FAULT_LIMIT=3, ERR_CNT_W=4). Expected values are hand-derived.
module tb_count_sequence_monitor;

  logic       clk;
  logic       rst_n;
  logic [2:0] cnt_in;
  logic       cnt_valid;
  logic       clear;
  logic       locked;
  logic       wrap_pulse;
  logic       err_pulse;
  logic [3:0] err_count;
  logic       fault;
  logic [2:0] expected;

  int n_checks = 0;
  int n_fail   = 0;

  count_sequence_monitor #(
    .WIDTH(3), .LOCK_COUNT(2), .FAULT_LIMIT(3), .ERR_CNT_W(4)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_cnt_in     (cnt_in),
    .i_cnt_valid  (cnt_valid),
    .i_clear      (clear),
    .o_locked     (locked),
    .o_wrap_pulse (wrap_pulse),
    .o_err_pulse  (err_pulse),
    .o_err_count  (err_count),
    .o_fault      (fault),
    .o_expected   (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Compare every output against one expected status vector
  task automatic check_all(input string tag, input logic e_locked, input logic e_wrap,
                           input logic e_err, input logic [3:0] e_cnt,
                           input logic e_fault, input logic [2:0] e_exp);
    check({tag, ".locked"},   32'(locked),     32'(e_locked));
    check({tag, ".wrap"},     32'(wrap_pulse), 32'(e_wrap));
    check({tag, ".err"},      32'(err_pulse),  32'(e_err));
    check({tag, ".err_cnt"},  32'(err_count),  32'(e_cnt));
    check({tag, ".fault"},    32'(fault),      32'(e_fault));
    check({tag, ".expected"}, 32'(expected),   32'(e_exp));
  endtask

  // Present one strobed sample; return #1 after the sampling edge
  task automatic drive(input logic [2:0] v);
    @(negedge clk);
    cnt_in    = v;
    cnt_valid = 1'b1;
    clear     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cnt_valid = 1'b0;
    clear     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    cnt_valid = 1'b0;
    clear     = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  logic [3:0] exp_cnt;
  logic [2:0] p;

  initial begin
    rst_n     = 1'b0;
    cnt_in    = '0;
    cnt_valid = 1'b0;
    clear     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock and wrap: 0..7,0,1; lock after sample 2, wrap after 7->0
    for (int i = 0; i < 10; i++) begin
      drive(3'(i));
      check_all($sformatf("lock_wrap[%0d]", i), (i >= 2), (i == 8), 1'b0, 4'd0,
                1'b0, 3'(i + 1));
    end
    idle_cycle();
    check_all("hold_gap", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd2);

    // Single glitch: 2,3 match, 5 mismatches, 6 matches again
    drive(3'd2);
    drive(3'd3);
    check_all("glitch_pre", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd4);
    drive(3'd5);
    check_all("glitch_err", 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 3'd6);
    drive(3'd6);
    check_all("glitch_resync", 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 3'd7);

    // Fault entry: fresh lock ending at 3, then 4 (match), 0,0,0
    do_clear();
    check_all("clear1", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    drive(3'd1);
    drive(3'd2);
    check("acq_not_locked", 32'(locked), 32'd0);
    drive(3'd3);
    check("acq_locked", 32'(locked), 32'd1);
    drive(3'd4);
    drive(3'd0);
    check_all("fault_m1", 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 3'd1);
    drive(3'd0);
    check_all("fault_m2", 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 3'd1);
    drive(3'd0);
    check_all("fault_m3", 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 3'd1);
    drive(3'd5);
    drive(3'd6);
    check_all("fault_hold", 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 3'd1);
    do_clear();
    check_all("fault_clear", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);

    // Saturation: lock on 0,1,2 then 20 isolated mismatches
    drive(3'd0);
    drive(3'd1);
    drive(3'd2);
    p       = 3'd2;
    exp_cnt = 4'd0;
    for (int i = 0; i < 20; i++) begin
      p = p + 3'd2;
      drive(p);
      if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
      check_all($sformatf("sat_err[%0d]", i), 1'b1, 1'b0, 1'b1, exp_cnt, 1'b0, p + 3'd1);
      p = p + 3'd1;
      drive(p);
      check(  $sformatf("sat_ok[%0d].err", i),   32'(err_pulse), 32'd0);
      check(  $sformatf("sat_ok[%0d].fault", i), 32'(fault),     32'd0);
    end
    check("sat_final", 32'(err_count), 32'd15);

    // Async reset mid-TRACK with err_count=2
    do_clear();
    drive(3'd0);
    drive(3'd1);
    drive(3'd2);
    drive(3'd5);
    drive(3'd6);
    drive(3'd0);
    drive(3'd1);
    check_all("pre_reset", 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 3'd2);
    cnt_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'd2);
    check_all("post_reset1", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd3);
    drive(3'd3);
    check("post_reset2.locked", 32'(locked), 32'd0);
    drive(3'd4);
    check("post_reset3.locked", 32'(locked), 32'd1);

    // Clear/valid collision in TRACK with a nonzero error count
    drive(3'd7);
    check_all("coll_pre_err", 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 3'd0);
    drive(3'd0);
    @(negedge clk);
    cnt_in    = 3'd5;
    cnt_valid = 1'b1;
    clear     = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_all("collision", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0);
    drive(3'd3);
    check_all("coll_after", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'd4);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
